// File: rtl/multiply_divide_unit_pkg.sv
// Shared op codes, state type and divide helpers for the multiply/divide unit.
package multiply_divide_unit_pkg;

    localparam logic [3:0] mdu_none  = 4'd0;
    localparam logic [3:0] mdu_mult  = 4'd1;
    localparam logic [3:0] mdu_multu = 4'd2;
    localparam logic [3:0] mdu_div   = 4'd3;
    localparam logic [3:0] mdu_divu  = 4'd4;
    localparam logic [3:0] mdu_mthi  = 4'd5;
    localparam logic [3:0] mdu_mtlo  = 4'd6;
    localparam logic [3:0] mdu_madd  = 4'd7;
    localparam logic [3:0] mdu_maddu = 4'd8;
    localparam logic [3:0] mdu_msub  = 4'd9;
    localparam logic [3:0] mdu_msubu = 4'd10;

    typedef enum logic {st_idle, st_run} mdu_state_t;

    // Returns {remainder, quotient}. Works on magnitudes so 0x80000000 / -1
    // wraps to 0x80000000 instead of overflowing; a zero divisor yields 0.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b[31] ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        r = a[31] ? (~r_mag + 32'd1) : r_mag;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

endpackage

// File: rtl/multiply_divide_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at start, committed after a fixed latency.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 7-10); otherwise they are no-ops.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ctrl,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int cw = $clog2(max_cycles + 1);

    // Handshake: start is honoured only in IDLE; while busy=1 it is dropped,
    // so the stall logic must hold the op until busy falls.
    mdu_state_t      state, state_n;
    logic [cw-1:0]   count, count_n;
    logic [63:0]     pending, pending_n;
    logic            commit, commit_n;
    logic [31:0]     hi_n, lo_n;

    logic [63:0]     prod_s, prod_u, div_s, div_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign div_s  = div_signed(A, B);
    assign div_u  = div_unsigned(A, B);

    always_comb begin
        state_n   = state;
        count_n   = count;
        pending_n = pending;
        commit_n  = commit;
        hi_n      = hi;
        lo_n      = lo;
        case (state)
            st_idle: begin
                if (start) begin
                    case (ctrl)
                        mdu_mult: begin
                            pending_n = prod_s;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_multu: begin
                            pending_n = prod_u;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
                        // A zero divisor still occupies the unit but never commits.
                        mdu_div: begin
                            pending_n = div_s;
                            commit_n  = (B != 32'd0);
                            count_n   = cw'(DIV_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_divu: begin
                            pending_n = div_u;
                            commit_n  = (B != 32'd0);
                            count_n   = cw'(DIV_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_mthi: hi_n = A;
                        mdu_mtlo: lo_n = A;
`ifdef MDU_MADD_EN
                        mdu_madd: begin
                            pending_n = {hi, lo} + prod_s;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_maddu: begin
                            pending_n = {hi, lo} + prod_u;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_msub: begin
                            pending_n = {hi, lo} - prod_s;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
                        mdu_msubu: begin
                            pending_n = {hi, lo} - prod_u;
                            commit_n  = 1'b1;
                            count_n   = cw'(MULT_CYCLES);
                            state_n   = st_run;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            st_run: begin
                count_n = count - cw'(1);
                if (count == cw'(1)) begin
                    state_n = st_idle;
                    if (commit) {hi_n, lo_n} = pending;
                end
            end
            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= st_idle;
            count   <= '0;
            pending <= 64'd0;
            commit  <= 1'b0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pending <= pending_n;
            commit  <= commit_n;
            busy    <= (count_n != '0);
            hi      <= hi_n;
            lo      <= lo_n;
        end
    end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Self-checking bench for multiply_divide_unit: directed steps plus random ops against an arithmetic model.
// Honours MDU_MADD_EN the same way the design does.
module tb_multiply_divide_unit;

    localparam int mult_lat = 5;
    localparam int div_lat  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  ctrl;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;
    logic [63:0] exp_q[$];

    multiply_divide_unit #(.MULT_CYCLES(mult_lat), .DIV_CYCLES(div_lat)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ctrl(ctrl),
        .start(start), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] hl, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {m_hi, m_lo};
        hl  = acc;
        lat = 0;
        case (op)
            4'd1: begin hl = sa * sb; lat = mult_lat; end
            4'd2: begin hl = ua * ub; lat = mult_lat; end
            4'd3: begin
                lat = div_lat;
                if (b != 0) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hl = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                lat = div_lat;
                if (b != 0) hl = {a % b, a / b};
            end
            4'd5: hl = {a, m_lo};
            4'd6: hl = {m_hi, a};
`ifdef MDU_MADD_EN
            4'd7:  begin hl = acc + 64'(sa * sb); lat = mult_lat; end
            4'd8:  begin hl = acc + ua * ub;      lat = mult_lat; end
            4'd9:  begin hl = acc - 64'(sa * sb); lat = mult_lat; end
            4'd10: begin hl = acc - ua * ub;      lat = mult_lat; end
`endif
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp_hl, old_hl;
        int exp_lat, n;
        old_hl = {m_hi, m_lo};
        model(op, a, b, exp_hl, exp_lat);
        exp_q.push_back(exp_hl);
        ctrl = op; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0; ctrl = 4'd0;
        if (exp_lat > 0) check({tag, " early"}, {hi, lo}, old_hl);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        check({tag, " lat"}, 64'(n), 64'(exp_lat));
        exp_hl = exp_q.pop_front();
        check({tag, " hilo"}, {hi, lo}, exp_hl);
        {m_hi, m_lo} = exp_hl;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int n;
        reset = 1'b1; start = 1'b0; ctrl = 4'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) tick();
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);

        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
        check("mult const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
        check("multu const", {hi, lo}, 64'h00000002_FFFFFFFA);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
        check("div const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2);
        check("divu const", {hi, lo}, 64'h00000001_00000003);
        run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div ovf const", {hi, lo}, 64'h00000000_80000000);

        // MTHI then MTLO on consecutive cycles: neither raises busy.
        ctrl = 4'd5; A = 32'h1234; start = 1'b1;
        tick();
        check("mthi busy", 64'(busy), 64'd0);
        ctrl = 4'd6; A = 32'h5678;
        tick();
        start = 1'b0; ctrl = 4'd0;
        check("mtlo busy", 64'(busy), 64'd0);
        check("mthi/mtlo hilo", {hi, lo}, 64'h00001234_00005678);
        m_hi = 32'h1234; m_lo = 32'h5678;
        run_op("div0", 4'd3, 32'd99, 32'd0);
        check("div0 const", {hi, lo}, 64'h00001234_00005678);

        // start while busy (busy cycle 2) must be dropped.
        ctrl = 4'd1; A = 32'd7; B = 32'd9; start = 1'b1;
        tick();
        start = 1'b0; ctrl = 4'd0;
        tick();
        ctrl = 4'd6; A = 32'hAAAA; start = 1'b1;
        tick();
        start = 1'b0; ctrl = 4'd0;
        n = 2;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        check("ignored start lat", 64'(n), 64'(mult_lat));
        check("ignored start hilo", {hi, lo}, 64'd63);
        m_hi = 32'd0; m_lo = 32'd63;

        // Reset in busy cycle 3 aborts the op with no later commit.
        ctrl = 4'd1; A = 32'h10000; B = 32'h10000; start = 1'b1;
        tick();
        start = 1'b0; ctrl = 4'd0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hilo", {hi, lo}, 64'd0);
        repeat (8) tick();
        check("midreset late busy", 64'(busy), 64'd0);
        check("midreset late hilo", {hi, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        run_op("mthi0", 4'd5, 32'd0, 32'd0);
        run_op("mtlo", 4'd6, 32'hFFFFFFFF, 32'd0);
        run_op("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu const", {hi, lo}, 64'h00000001_00000000);
`else
        check("maddu const", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = 32'hFFFFFFFF - $urandom_range(0, 5);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, op), op, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
